// File: rtl/game_pkg.sv
// Shared encodings for the game datapath: FSM states, movement directions
// and the opposite-direction rule used to reject reversing moves.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Up/down and left/right pairs differ only in bit 0.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter: one-hot grant searched from the index after
// the last grant; the pointer only advances when grant_en accepts a grant.
module rr_arbiter4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] request,
    input  logic       grant_en,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_any
);

    logic [1:0] ptr_q;
    logic [1:0] cand;

    always_comb begin
        grant     = 4'b0000;
        grant_idx = ptr_q;
        grant_any = 1'b0;
        cand      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!grant_any && request[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else if (grant_en && grant_any) begin
            ptr_q <= grant_idx + 2'd1;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Game sequencer: FSM, frame-aligned move strobe, direction arbitration and score.
// Optional MOVE_SPEEDUP_EN: every 8th point shortens the move period (floor 1).
module move_scheduler
    import game_pkg::*;
#(
    parameter int FRAMES_PER_MOVE = 4,
    parameter int SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               start_p,
    input  logic [3:0]         req,
    input  logic               collision,
    input  logic               point,
    output logic               move_en,
    output logic [1:0]         dir,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [3:0] PERIOD_INIT = 4'(FRAMES_PER_MOVE);

    state_t             state_q, state_d;
    logic [3:0]         fcnt_q;
    logic [3:0]         pend_q;
    logic [1:0]         dir_q;
    logic [SCORE_W-1:0] score_q;
    logic               move_en_q;
    logic [3:0]         period;
    logic               in_run, start_run, move_cycle;
    logic [3:0]         grant;
    logic [1:0]         grant_idx;
    logic               grant_any;

    assign in_run     = (state_q == ST_RUN);
    assign start_run  = (state_q == ST_IDLE) && start_p;
    // >= keeps the wrap reachable if a speedup shrinks the period below fcnt.
    assign move_cycle = in_run && frame_start && (fcnt_q >= period - 4'd1);

    rr_arbiter4 u_arb (
        .clk       (clk),
        .rst       (rst),
        .request   (pend_q),
        .grant_en  (move_cycle),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_p) state_d = ST_RUN;
            ST_RUN: begin
                if (collision)    state_d = ST_OVER;
                else if (start_p) state_d = ST_PAUSE;
            end
            ST_PAUSE: if (start_p) state_d = ST_RUN;
            default:  if (start_p) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q    <= 4'd0;
            pend_q    <= 4'd0;
            dir_q     <= DIR_RIGHT;
            score_q   <= '0;
            move_en_q <= 1'b0;
        end else begin
            move_en_q <= move_cycle;
            if (start_run) begin
                fcnt_q  <= 4'd0;
                pend_q  <= 4'd0;
                dir_q   <= DIR_RIGHT;
                score_q <= '0;
            end else if (in_run) begin
                if (frame_start) begin
                    fcnt_q <= move_cycle ? 4'd0 : fcnt_q + 4'd1;
                end
                if (move_cycle && grant_any && (grant_idx != opposite_dir(dir_q))) begin
                    dir_q <= grant_idx;
                end
                // New requests override the clear of a bit granted this cycle.
                pend_q <= (pend_q & ~(move_cycle ? grant : 4'b0000)) | req;
                if (point && (score_q != {SCORE_W{1'b1}})) begin
                    score_q <= score_q + 1'b1;
                end
            end
        end
    end

`ifdef MOVE_SPEEDUP_EN
    logic [3:0] period_q;
    logic [2:0] sub_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= PERIOD_INIT;
            sub_q    <= 3'd0;
        end else if (start_run) begin
            period_q <= PERIOD_INIT;
            sub_q    <= 3'd0;
        end else if (in_run && point) begin
            sub_q <= sub_q + 3'd1;
            if ((sub_q == 3'd7) && (period_q > 4'd1)) begin
                period_q <= period_q - 4'd1;
            end
        end
    end

    assign period = period_q;
`else
    assign period = PERIOD_INIT;
`endif

    assign move_en   = move_en_q;
    assign dir       = dir_q;
    assign state     = state_q;
    assign score     = score_q;
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_move_scheduler.sv
// Directed plus randomized bench for move_scheduler against a behavioural model.
// A 4-bit score keeps the saturation boundary reachable in a short run.
module tb_move_scheduler;

    localparam int FPM       = 4;
    localparam int SW        = 4;
    localparam int SCORE_MAX = (1 << SW) - 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVER = 3;

    logic          clk = 1'b0;
    logic          rst, frame_start, start_p, collision, point;
    logic [3:0]    req;
    logic          move_en, game_over;
    logic [1:0]    dir, state;
    logic [SW-1:0] score;

    int passCount  = 0;
    int checkCount = 0;

    int m_state, m_dir, m_score, m_fcnt, m_last;
    bit m_move;
    bit m_pend [4];

    always #5 clk = ~clk;

    move_scheduler #(.FRAMES_PER_MOVE(FPM), .SCORE_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .start_p     (start_p),
        .req         (req),
        .collision   (collision),
        .point       (point),
        .move_en     (move_en),
        .dir         (dir),
        .state       (state),
        .score       (score),
        .game_over   (game_over)
    );

    task automatic modelReset();
        m_state = S_IDLE;
        m_dir   = 3;
        m_score = 0;
        m_fcnt  = 0;
        m_last  = 3;
        m_move  = 1'b0;
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    endtask

    // One clock of game rules, computed from the pre-edge state and inputs.
    task automatic modelStep(input bit fs, input bit sp, input bit [3:0] rq,
                             input bit col, input bit pt);
        int nxt;
        bit mv;
        nxt = m_state;
        mv  = 1'b0;
        case (m_state)
            S_IDLE: if (sp) begin
                nxt     = S_RUN;
                m_score = 0;
                m_fcnt  = 0;
                m_dir   = 3;
                for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            end
            S_RUN: begin
                if (col)     nxt = S_OVER;
                else if (sp) nxt = S_PAUSE;
                mv = fs && (m_fcnt == FPM - 1);
                if (fs) m_fcnt = mv ? 0 : m_fcnt + 1;
                if (mv) begin
                    for (int k = 1; k <= 4; k++) begin
                        int idx;
                        idx = (m_last + k) % 4;
                        if (m_pend[idx]) begin
                            m_pend[idx] = 1'b0;
                            m_last      = idx;
                            if (!((idx / 2 == m_dir / 2) && (idx != m_dir))) m_dir = idx;
                            break;
                        end
                    end
                end
                for (int b = 0; b < 4; b++) if (rq[b]) m_pend[b] = 1'b1;
                if (pt && (m_score < SCORE_MAX)) m_score = m_score + 1;
            end
            S_PAUSE: if (sp) nxt = S_RUN;
            default: if (sp) nxt = S_IDLE;
        endcase
        m_state = nxt;
        m_move  = mv;
    endtask

    task automatic checkOutput(input string tag);
        checkCount++;
        assert (move_en === m_move) begin passCount++; end
        else $error("FAIL %s move_en got %b expected %b", tag, move_en, m_move);
        checkCount++;
        assert (dir === 2'(m_dir)) begin passCount++; end
        else $error("FAIL %s dir got %0d expected %0d", tag, dir, m_dir);
        checkCount++;
        assert (state === 2'(m_state)) begin passCount++; end
        else $error("FAIL %s state got %0d expected %0d", tag, state, m_state);
        checkCount++;
        assert (score === SW'(m_score)) begin passCount++; end
        else $error("FAIL %s score got %0d expected %0d", tag, score, m_score);
        checkCount++;
        assert (game_over === (m_state == S_OVER)) begin passCount++; end
        else $error("FAIL %s game_over got %b expected %b", tag, game_over, (m_state == S_OVER));
    endtask

    task automatic applyStimulus(input bit fs, input bit sp, input bit [3:0] rq,
                                 input bit col, input bit pt, input string tag);
        frame_start = fs;
        start_p     = sp;
        req         = rq;
        collision   = col;
        point       = pt;
        modelStep(fs, sp, rq, col, pt);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic frameGap(input int n, input string tag);
        for (int f = 0; f < n; f++) begin
            applyStimulus(1, 0, 4'b0000, 0, 0, tag);
            applyStimulus(0, 0, 4'b0000, 0, 0, tag);
            applyStimulus(0, 0, 4'b0000, 0, 0, tag);
        end
    endtask

    initial begin
        bit [3:0] rq;
        rst = 1'b1; frame_start = 1'b0; start_p = 1'b0;
        req = 4'b0000; collision = 1'b0; point = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b0;

        applyStimulus(0, 0, 4'b0000, 0, 0, "idle");
        applyStimulus(1, 0, 4'b0001, 1, 1, "idle_ignore");
        applyStimulus(0, 1, 4'b0000, 0, 0, "start");
        frameGap(8, "eight_frames");

        applyStimulus(0, 0, 4'b0001, 0, 0, "req_up");
        applyStimulus(0, 0, 4'b1000, 0, 0, "req_right");
        frameGap(8, "two_moves");

        applyStimulus(0, 0, 4'b0100, 0, 0, "req_left");
        frameGap(4, "opposite_drop");

        frameGap(2, "pre_pause");
        applyStimulus(0, 1, 4'b0000, 0, 0, "pause");
        applyStimulus(0, 0, 4'b0010, 0, 1, "pause_ignore");
        frameGap(10, "paused");
        applyStimulus(0, 1, 4'b0000, 0, 0, "resume");
        frameGap(4, "resumed");

        for (int p = 0; p < SCORE_MAX + 2; p++) applyStimulus(0, 0, 4'b0000, 0, 1, "score_sat");

        applyStimulus(0, 0, 4'b0000, 0, 0, "pre_async");
        rst = 1'b1;
        #2;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(0, 1, 4'b0000, 0, 0, "restart");
        frameGap(2, "run");
        applyStimulus(0, 1, 4'b0000, 1, 0, "collision_wins");
        applyStimulus(0, 0, 4'b0000, 1, 1, "over_hold");
        applyStimulus(0, 1, 4'b0000, 0, 0, "over_to_idle");

        $display("[TB] randomized phase");
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(7) == 0);
            applyStimulus(($urandom_range(2) == 0), ($urandom_range(39) == 0), rq,
                          ($urandom_range(79) == 0), ($urandom_range(3) == 0), "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
